// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner: per-frame input snapshot,
// character decode, per-digit decimal point and blink, registered outputs.
module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [39:0] digits_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  blink_i,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        frame_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [4:0] CHAR_BLK = 5'd31;

    logic [CW-1:0] count_reg, count_next;
    logic [2:0]    idx_reg, idx_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic [39:0]   snap_digits_reg;
    logic [7:0]    snap_dp_reg;
    logic [7:0]    snap_blink_reg;
    logic [7:0]    an_reg, an_next;
    logic [7:0]    seg_reg, seg_next;
    logic          tick;
    logic          snap;
    logic [4:0]    digit_code [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_code[gi] = snap_digits_reg[5*gi +: 5];
        end
    endgenerate

    // Segment order {g,f,e,d,c,b,a}; unknown codes and CHAR_BLK are dark.
    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'h3F;
            5'd1:    decode = 7'h06;
            5'd2:    decode = 7'h5B;
            5'd3:    decode = 7'h4F;
            5'd4:    decode = 7'h66;
            5'd5:    decode = 7'h6D;
            5'd6:    decode = 7'h7D;
            5'd7:    decode = 7'h07;
            5'd8:    decode = 7'h7F;
            5'd9:    decode = 7'h6F;
            5'd10:   decode = 7'h77;
            5'd11:   decode = 7'h7C;
            5'd12:   decode = 7'h39;
            5'd13:   decode = 7'h5E;
            5'd14:   decode = 7'h79;
            5'd15:   decode = 7'h71;
            5'd16:   decode = 7'h78;
            5'd17:   decode = 7'h1E;
            5'd18:   decode = 7'h50;
            5'd19:   decode = 7'h76;
            5'd20:   decode = 7'h73;
            5'd21:   decode = 7'h38;
            5'd22:   decode = 7'h3E;
            5'd23:   decode = 7'h6D;
            5'd24:   decode = 7'h54;
            5'd25:   decode = 7'h40;
            5'd26:   decode = 7'h08;
            default: decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        tick             = (count_reg == CW'(SCAN_DIV - 1));
        snap             = tick && (idx_reg == 3'd7);
        count_next       = tick ? '0 : count_reg + CW'(1);
        idx_next         = tick ? idx_reg + 3'd1 : idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (snap) begin
            if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + FW'(1);
            end
        end

        // Blanking during the off phase also suppresses the decimal point.
        seg_next = {snap_dp_reg[idx_reg], decode(digit_code[idx_reg])};
        if (snap_blink_reg[idx_reg] && blink_phase_reg)
            seg_next = 8'h00;
        an_next = 8'h01 << idx_reg;
        if (!en_i) begin
            seg_next = 8'h00;
            an_next  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg       <= '0;
            idx_reg         <= 3'd0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            snap_digits_reg <= {8{CHAR_BLK}};
            snap_dp_reg     <= 8'h00;
            snap_blink_reg  <= 8'h00;
            an_reg          <= 8'h00;
            seg_reg         <= 8'h00;
        end else begin
            count_reg       <= count_next;
            idx_reg         <= idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            if (snap) begin
                snap_digits_reg <= digits_i;
                snap_dp_reg     <= dp_i;
                snap_blink_reg  <= blink_i;
            end
        end
    end

    assign an_o    = an_reg;
    assign seg_o   = seg_reg;
    assign frame_o = snap && !rst;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2; outputs sampled on negedge.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b1;
    logic [39:0] digits_i = '0;
    logic [7:0]  dp_i = 8'h00;
    logic [7:0]  blink_i = 8'h00;
    logic [7:0]  an_o;
    logic [7:0]  seg_o;
    logic        frame_o;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] DEC [32] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
        8'h78, 8'h1E, 8'h50, 8'h76, 8'h73, 8'h38, 8'h3E, 8'h6D,
        8'h54, 8'h40, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .digits_i (digits_i),
        .dp_i     (dp_i),
        .blink_i  (blink_i),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("t=%0t %s observed=%h expected=%h", $time, tag, obs, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stops on the negedge of the next frame_o cycle, bounded to 64 cycles.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_o !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {7'd0, frame_o}, 8'h01);
    endtask

    // Called at the negedge where rst was just dropped; returns at the first frame_o.
    task automatic blank_frame_check(input string tag);
        int bad_seg;
        int bad_frame;
        bad_seg = 0;
        bad_frame = 0;
        adv(1);
        chk({tag, "_an_first"}, an_o, 8'h01);
        for (int i = 1; i <= 30; i++) begin
            if (i > 1) adv(1);
            if (seg_o !== 8'h00) bad_seg++;
            if (frame_o !== 1'b0) bad_frame++;
        end
        chk({tag, "_blank_seg_count"}, 8'(bad_seg), 8'h00);
        chk({tag, "_early_frame_count"}, 8'(bad_frame), 8'h00);
        adv(1);
        chk({tag, "_frame_at_31"}, {7'd0, frame_o}, 8'h01);
    endtask

    initial begin
        // Reset state and first frame after release
        digits_i = {8{5'd8}};
        adv(3);
        chk("rst_an", an_o, 8'h00);
        chk("rst_seg", seg_o, 8'h00);
        chk("rst_frame", {7'd0, frame_o}, 8'h00);
        rst = 1'b0;
        blank_frame_check("init");
        adv(2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("init_an_d%0d", k), an_o, 8'h01 << k);
            chk($sformatf("init_seg_d%0d", k), seg_o, 8'h7F);
            adv(4);
        end

        // Decode sweep on digit 0
        for (int c = 0; c < 32; c++) begin
            digits_i = {{7{5'd8}}, 5'(c)};
            wait_frame($sformatf("dec_frame_%0d", c));
            adv(2);
            chk($sformatf("dec_an_%0d", c), an_o, 8'h01);
            chk($sformatf("dec_seg_%0d", c), seg_o, DEC[c]);
        end
        dp_i = 8'h01;
        digits_i = {{7{5'd8}}, 5'd8};
        wait_frame("dp8_frame");
        adv(2);
        chk("dp_seg_8", seg_o, 8'hFF);
        digits_i = {{7{5'd8}}, 5'd31};
        wait_frame("dp_blk_frame");
        adv(2);
        chk("dp_seg_blk", seg_o, 8'h80);
        dp_i = 8'h00;

        // Tear-free snapshot
        digits_i = {8{5'd1}};
        wait_frame("tear_frame1");
        adv(2);
        chk("tear_d0", seg_o, 8'h06);
        adv(12);
        chk("tear_an_d3", an_o, 8'h08);
        digits_i = {8{5'd2}};
        chk("tear_seg_d3", seg_o, 8'h06);
        for (int k = 4; k < 8; k++) begin
            adv(4);
            chk($sformatf("tear_an_d%0d", k), an_o, 8'h01 << k);
            chk($sformatf("tear_seg_d%0d", k), seg_o, 8'h06);
        end
        wait_frame("tear_frame2");
        adv(2);
        chk("tear_new_d0", seg_o, 8'h5B);

        // Enable drop at idx 5, resume at idx 7
        wait_frame("en_frame");
        adv(21);
        en_i = 1'b0;
        adv(1);
        chk("en_off_an", an_o, 8'h00);
        chk("en_off_seg", seg_o, 8'h00);
        adv(3);
        chk("en_off_an_hold", an_o, 8'h00);
        adv(6);
        en_i = 1'b1;
        adv(1);
        chk("en_resume_an", an_o, 8'h80);
        chk("en_resume_seg", seg_o, 8'h5B);

        // Reset at idx 6, then blink sequence from a known phase
        wait_frame("mrst_frame");
        adv(26);
        rst = 1'b1;
        digits_i = {8{5'd1}};
        dp_i = 8'h01;
        blink_i = 8'h01;
        adv(1);
        chk("mrst_an", an_o, 8'h00);
        chk("mrst_seg", seg_o, 8'h00);
        chk("mrst_frame", {7'd0, frame_o}, 8'h00);
        adv(1);
        chk("mrst_an_hold", an_o, 8'h00);
        rst = 1'b0;
        blank_frame_check("mrst");
        for (int j = 1; j <= 8; j++) begin
            if (j > 1) wait_frame($sformatf("blink_frame_%0d", j));
            adv(2);
            chk($sformatf("blink_an0_f%0d", j), an_o, 8'h01);
            chk($sformatf("blink_seg0_f%0d", j), seg_o,
                ((j % 4 == 2) || (j % 4 == 3)) ? 8'h00 : 8'h86);
            adv(4);
            chk($sformatf("blink_an1_f%0d", j), an_o, 8'h02);
            chk($sformatf("blink_seg1_f%0d", j), seg_o, 8'h06);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
